// File: rtl/waterfall_wr_ctrl.sv
// Write-side controller for the two-bank waterfall spectrogram RAM.
// Keeps the lower half of each FFT frame in a ring of rows and publishes the oldest row only at vblank.
module waterfall_wr_ctrl #(
   parameter int NO_BANKS       = 2,
   parameter int RAM_ADDR_WIDTH = 12,
   parameter int NO_FFTS        = 50,
   parameter int FFT_SIZE       = 256,
   parameter int DATA_W         = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_last,
   input  logic                       vblank,
   output logic                       wr_en,
   output logic [NO_BANKS-1:0]        wr_bank_select,
   output logic [RAM_ADDR_WIDTH-1:0]  wr_address,
   output logic [DATA_W-1:0]          wr_data,
   output logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx,
   output logic                       frame_err
);

   localparam int IDX_W = $clog2(NO_FFTS);
   localparam int HALF  = FFT_SIZE / 2;
   localparam int BIN_W = $clog2(HALF);
   localparam int CNT_W = $clog2(FFT_SIZE);

   typedef enum logic [1:0] {
      ACCEPT  = 2'd0,
      COMMIT  = 2'd1,
      WAIT_VB = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]          pending_q, pending_d;
   logic [IDX_W-1:0]          oldest_q, oldest_d;
   logic [CNT_W-1:0]          bin_cnt_q, bin_cnt_d;
   logic                      s_ready_q, s_ready_d;
   logic                      vblank_dly_q, vblank_dly_d;
   logic                      wr_en_q, wr_en_d;
   logic [NO_BANKS-1:0]       bank_q, bank_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic                      err_q, err_d;
   logic                      xfer;
   logic                      vb_rise;

   always_comb begin
      state_d      = state_q;
      wr_idx_d     = wr_idx_q;
      pending_d    = pending_q;
      oldest_d     = oldest_q;
      bin_cnt_d    = bin_cnt_q;
      vblank_dly_d = vblank;
      wr_en_d      = 1'b0;
      bank_d       = '0;
      addr_d       = '0;
      data_d       = '0;
      err_d        = 1'b0;
      xfer         = s_valid & s_ready_q;
      vb_rise      = vblank & ~vblank_dly_q;

      case (state_q)
         ACCEPT: begin
            if (xfer) begin
               if (bin_cnt_q < CNT_W'(HALF)) begin
                  wr_en_d = 1'b1;
                  bank_d  = NO_BANKS'(1) << wr_idx_q[IDX_W-1];
                  addr_d  = RAM_ADDR_WIDTH'({wr_idx_q[IDX_W-2:0], bin_cnt_q[BIN_W-1:0]});
                  data_d  = s_data;
               end
               // Beat count, not s_last, ends a frame; a missing s_last still commits.
               if (bin_cnt_q == CNT_W'(FFT_SIZE - 1)) begin
                  err_d     = ~s_last;
                  bin_cnt_d = '0;
                  state_d   = COMMIT;
               end else if (s_last) begin
                  err_d     = 1'b1;
                  bin_cnt_d = '0;
               end else begin
                  bin_cnt_d = bin_cnt_q + CNT_W'(1);
               end
            end
         end
         COMMIT: begin
            pending_d = (wr_idx_q == IDX_W'(NO_FFTS - 1)) ? '0 : wr_idx_q + IDX_W'(1);
            wr_idx_d  = pending_d;
            bin_cnt_d = '0;
            state_d   = WAIT_VB;
         end
         WAIT_VB: begin
            if (vb_rise) begin
               oldest_d = pending_q;
               state_d  = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase

      // Registered so s_ready stays low through reset and rises one cycle after release.
      s_ready_d = (state_d == ACCEPT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACCEPT;
         wr_idx_q     <= '0;
         pending_q    <= '0;
         oldest_q     <= '0;
         bin_cnt_q    <= '0;
         s_ready_q    <= 1'b0;
         vblank_dly_q <= 1'b0;
         wr_en_q      <= 1'b0;
         bank_q       <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_idx_q     <= wr_idx_d;
         pending_q    <= pending_d;
         oldest_q     <= oldest_d;
         bin_cnt_q    <= bin_cnt_d;
         s_ready_q    <= s_ready_d;
         vblank_dly_q <= vblank_dly_d;
         wr_en_q      <= wr_en_d;
         bank_q       <= bank_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         err_q        <= err_d;
      end
   end

   assign s_ready        = s_ready_q;
   assign wr_en          = wr_en_q;
   assign wr_bank_select = bank_q;
   assign wr_address     = addr_q;
   assign wr_data        = data_q;
   assign oldest_fft_idx = oldest_q;
   assign frame_err      = err_q;

endmodule
